aes_cipher_core: RTL and testbench

Parametrised iterative AES engine executing one round per clock in either encrypt or decrypt mode, selected per block. Supports AES-128/192/256 through `nk`/`nr`, accepts a precomputed key schedule from the key-expansion stage, and exchanges blocks over valid/ready handshakes. It sits between the key-expansion block and the system datapath, replacing the fixed-length, decrypt-only round sequencer.

---
 rtl/aes_cipher_core.sv | 207 ++++++++++++++++++++
 tb/tb_aes_cipher_core.sv | 368 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/aes_cipher_core.sv
// Iterative AES engine, one round per clock, encrypt or decrypt per block.
// AES-128/192/256 selected by nk/nr; round keys come precomputed from key expansion.
module aes_cipher_core #(
  parameter int nk = 4,
  parameter int nr = 10
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic                   mode,
  input  logic [0:127]           Message,
  input  logic [0:128*(nr+1)-1]  keySchedule,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [0:127]           result,
  output logic                   busy
);

  localparam int RW = $clog2(nr + 1);

  if (nr != nk + 6 || (nk != 4 && nk != 6 && nk != 8)) begin : g_bad_cfg
    $error("aes_cipher_core: nk must be 4/6/8 and nr must equal nk+6");
  end

  // byte 0 is the most significant byte; byte index = 4*column + row
  typedef logic [0:15][7:0] blk_t;
  typedef enum logic [1:0] {IDLE, ROUND, DONE} fsm_t;

  fsm_t            fsm;
  blk_t            st;
  logic [RW-1:0]   r;
  logic            mode_q;
  logic [127:0]    rk [0:nr];
  logic [RW-1:0]   ki;
  logic            last;
  logic            accept;
  blk_t            rnd_out;
  blk_t            init_st;

  for (genvar i = 0; i <= nr; i++) begin : g_rk
    assign rk[i] = keySchedule[128*i +: 128];
  end

  function automatic logic [7:0] xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x;
    p = '0;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[3'(i)]) p = p ^ x;
      x = xt(x);
    end
    return p;
  endfunction

  // a^254 is the multiplicative inverse in GF(2^8), and maps 0 to 0
  function automatic logic [7:0] ginv(input logic [7:0] a);
    logic [7:0] p, q;
    p = a;
    q = 8'h01;
    for (int i = 1; i < 8; i++) begin
      p = gmul(p, p);
      q = gmul(q, p);
    end
    return q;
  endfunction

  function automatic logic [7:0] sbox(input logic [7:0] a);
    logic [7:0] b;
    b = ginv(a);
    return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]} ^ {b[3:0], b[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [7:0] isbox(input logic [7:0] a);
    return ginv({a[6:0], a[7]} ^ {a[4:0], a[7:5]} ^ {a[1:0], a[7:2]} ^ 8'h05);
  endfunction

  function automatic blk_t subBytes(input blk_t s, input logic inv);
    blk_t o;
    for (int i = 0; i < 16; i++) o[4'(i)] = inv ? isbox(s[4'(i)]) : sbox(s[4'(i)]);
    return o;
  endfunction

  function automatic blk_t shiftRows(input blk_t s, input logic inv);
    blk_t o;
    for (int c = 0; c < 4; c++)
      for (int w = 0; w < 4; w++)
        if (inv) o[4'(4*((c + w) & 3) + w)] = s[4'(4*c + w)];
        else     o[4'(4*c + w)] = s[4'(4*((c + w) & 3) + w)];
    return o;
  endfunction

  function automatic blk_t mixColumns(input blk_t s);
    blk_t o;
    logic [7:0] a [4];
    for (int c = 0; c < 4; c++) begin
      for (int w = 0; w < 4; w++) a[w] = s[4'(4*c + w)];
      o[4'(4*c)]     = xt(a[0]) ^ xt(a[1]) ^ a[1] ^ a[2] ^ a[3];
      o[4'(4*c + 1)] = a[0] ^ xt(a[1]) ^ xt(a[2]) ^ a[2] ^ a[3];
      o[4'(4*c + 2)] = a[0] ^ a[1] ^ xt(a[2]) ^ xt(a[3]) ^ a[3];
      o[4'(4*c + 3)] = xt(a[0]) ^ a[0] ^ a[1] ^ a[2] ^ xt(a[3]);
    end
    return o;
  endfunction

  function automatic blk_t invMixColumns(input blk_t s);
    blk_t o;
    logic [7:0] a [4];
    for (int c = 0; c < 4; c++) begin
      for (int w = 0; w < 4; w++) a[w] = s[4'(4*c + w)];
      o[4'(4*c)]     = gmul(a[0], 8'h0e) ^ gmul(a[1], 8'h0b) ^ gmul(a[2], 8'h0d) ^ gmul(a[3], 8'h09);
      o[4'(4*c + 1)] = gmul(a[0], 8'h09) ^ gmul(a[1], 8'h0e) ^ gmul(a[2], 8'h0b) ^ gmul(a[3], 8'h0d);
      o[4'(4*c + 2)] = gmul(a[0], 8'h0d) ^ gmul(a[1], 8'h09) ^ gmul(a[2], 8'h0e) ^ gmul(a[3], 8'h0b);
      o[4'(4*c + 3)] = gmul(a[0], 8'h0b) ^ gmul(a[1], 8'h0d) ^ gmul(a[2], 8'h09) ^ gmul(a[3], 8'h0e);
    end
    return o;
  endfunction

  function automatic blk_t addRoundKey(input blk_t s, input logic [127:0] k);
    return s ^ k;
  endfunction

  function automatic blk_t encryptRound(input blk_t s, input logic [127:0] k);
    return addRoundKey(mixColumns(shiftRows(subBytes(s, 1'b0), 1'b0)), k);
  endfunction

  function automatic blk_t encryptLastRound(input blk_t s, input logic [127:0] k);
    return addRoundKey(shiftRows(subBytes(s, 1'b0), 1'b0), k);
  endfunction

  function automatic blk_t decryptRound(input blk_t s, input logic [127:0] k);
    return invMixColumns(addRoundKey(subBytes(shiftRows(s, 1'b1), 1'b1), k));
  endfunction

  function automatic blk_t decryptLastRound(input blk_t s, input logic [127:0] k);
    return addRoundKey(subBytes(shiftRows(s, 1'b1), 1'b1), k);
  endfunction

  assign in_ready = reset && (fsm == IDLE || (fsm == DONE && out_ready));
  assign accept   = in_valid && in_ready;
  assign last     = (r == RW'(nr));
  // decryption walks the schedule backwards
  assign ki       = mode_q ? RW'(nr) - r : r;
  assign init_st  = addRoundKey(Message, mode ? rk[nr] : rk[0]);

  always_comb begin
    rnd_out = st;
    case ({mode_q, last})
      2'b00:   rnd_out = encryptRound(st, rk[ki]);
      2'b01:   rnd_out = encryptLastRound(st, rk[ki]);
      2'b10:   rnd_out = decryptRound(st, rk[ki]);
      default: rnd_out = decryptLastRound(st, rk[ki]);
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fsm       <= IDLE;
      st        <= '0;
      r         <= '0;
      mode_q    <= 1'b0;
      result    <= '0;
      out_valid <= 1'b0;
      busy      <= 1'b0;
    end else begin
      case (fsm)
        IDLE: if (accept) begin
          st     <= init_st;
          r      <= RW'(1);
          mode_q <= mode;
          busy   <= 1'b1;
          fsm    <= ROUND;
        end
        ROUND: begin
          st <= rnd_out;
          if (last) begin
            result    <= rnd_out;
            out_valid <= 1'b1;
            busy      <= 1'b0;
            fsm       <= DONE;
          end else begin
            r <= r + RW'(1);
          end
        end
        DONE: if (out_ready) begin
          out_valid <= 1'b0;
          // same-cycle handoff and accept goes straight back to ROUND
          if (in_valid) begin
            st     <= init_st;
            r      <= RW'(1);
            mode_q <= mode;
            busy   <= 1'b1;
            fsm    <= ROUND;
          end else begin
            fsm <= IDLE;
          end
        end
        default: fsm <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_aes_cipher_core.sv
// Bench for aes_cipher_core: three instances (AES-128/192/256) checked against
// a table-driven AES model built from GF(2^8) arithmetic at time zero.
module tb_aes_cipher_core;

  localparam logic [255:0] KEY = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
  localparam logic [127:0] PT  = 128'h00112233445566778899aabbccddeeff;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         mode;
  logic         out_ready;
  logic [127:0] msg;
  logic         iv [3];
  logic         ir [3];
  logic         ov [3];
  logic         bz [3];
  logic [127:0] rs [3];
  logic [1919:0] ksf [3];
  logic [0:1407] ks4;
  logic [0:1663] ks6;
  logic [0:1919] ks8;
  logic [7:0]   sb [256];
  logic [7:0]   isb [256];
  int           vecs = 0;
  int           errs = 0;

  assign ks4 = ksf[0][1919 -: 1408];
  assign ks6 = ksf[1][1919 -: 1664];
  assign ks8 = ksf[2][1919 -: 1920];

  always #5 clk = ~clk;

  aes_cipher_core #(.nk(4), .nr(10)) dut4 (
    .clk(clk), .reset(rst_n), .in_valid(iv[0]), .in_ready(ir[0]), .mode(mode), .Message(msg),
    .keySchedule(ks4), .out_valid(ov[0]), .out_ready(out_ready), .result(rs[0]), .busy(bz[0]));
  aes_cipher_core #(.nk(6), .nr(12)) dut6 (
    .clk(clk), .reset(rst_n), .in_valid(iv[1]), .in_ready(ir[1]), .mode(mode), .Message(msg),
    .keySchedule(ks6), .out_valid(ov[1]), .out_ready(out_ready), .result(rs[1]), .busy(bz[1]));
  aes_cipher_core #(.nk(8), .nr(14)) dut8 (
    .clk(clk), .reset(rst_n), .in_valid(iv[2]), .in_ready(ir[2]), .mode(mode), .Message(msg),
    .keySchedule(ks8), .out_valid(ov[2]), .out_ready(out_ready), .result(rs[2]), .busy(bz[2]));

  // ---------------- reference model ----------------
  function automatic logic [7:0] gm(input logic [7:0] a, input logic [7:0] b);
    int p = 0, x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = x << 1;
      if (x & 'h100) x = x ^ 'h11b;
    end
    return p[7:0];
  endfunction

  task automatic build_tables();
    logic [7:0] inv, s;
    for (int a = 0; a < 256; a++) begin
      inv = 8'h00;
      for (int b = 1; b < 256 && a != 0; b++) if (gm(8'(a), 8'(b)) == 8'h01) inv = 8'(b);
      for (int i = 0; i < 8; i++)
        s[i] = inv[i] ^ inv[(i+4)%8] ^ inv[(i+5)%8] ^ inv[(i+6)%8] ^ inv[(i+7)%8] ^ (8'h63 >> i) & 1'b1;
      sb[a]  = s;
      isb[s] = 8'(a);
    end
  endtask

  function automatic logic [31:0] subw(input logic [31:0] w);
    return {sb[w[31:24]], sb[w[23:16]], sb[w[15:8]], sb[w[7:0]]};
  endfunction

  function automatic logic [1919:0] expand(input int nk, input logic [255:0] key);
    logic [31:0] w [60];
    logic [31:0] t;
    logic [7:0]  rc = 8'h01;
    logic [1919:0] ks = '0;
    int nw = 4 * (nk + 7);
    for (int i = 0; i < nk; i++) w[i] = key[255-32*i -: 32];
    for (int i = nk; i < nw; i++) begin
      t = w[i-1];
      if (i % nk == 0) begin
        t  = subw({t[23:0], t[31:24]}) ^ {rc, 24'h0};
        rc = gm(rc, 8'h02);
      end else if (nk > 6 && i % nk == 4) begin
        t = subw(t);
      end
      w[i] = w[i-nk] ^ t;
    end
    for (int i = 0; i < nw; i++) ks[1919-32*i -: 32] = w[i];
    return ks;
  endfunction

  // FIPS-197 Cipher / InvCipher on a 4x4 row/column state matrix
  function automatic logic [127:0] model(input int nr, input logic [1919:0] ks,
                                         input logic dec, input logic [127:0] m);
    logic [7:0] st [4][4];
    logic [7:0] tp [4][4];
    logic [7:0] v;
    logic [127:0] o;
    int ce [4] = '{2, 3, 1, 1};
    int cd [4] = '{14, 11, 13, 9};
    for (int c = 0; c < 4; c++) for (int w = 0; w < 4; w++) st[w][c] = m[127-8*(4*c+w) -: 8];
    for (int k = 0; k <= nr; k++) begin
      int rd = dec ? nr - k : k;
      if (!dec && rd > 0) begin
        tp = st;
        for (int w = 0; w < 4; w++) for (int c = 0; c < 4; c++) st[w][c] = sb[tp[w][(c+w)%4]];
        if (rd < nr) begin
          tp = st;
          for (int w = 0; w < 4; w++) for (int c = 0; c < 4; c++) begin
            v = 8'h00;
            for (int j = 0; j < 4; j++) v = v ^ gm(8'(ce[(j-w+4)%4]), tp[j][c]);
            st[w][c] = v;
          end
        end
      end
      if (dec && rd < nr) begin
        tp = st;
        for (int w = 0; w < 4; w++) for (int c = 0; c < 4; c++) st[w][(c+w)%4] = isb[tp[w][c]];
      end
      for (int c = 0; c < 4; c++) for (int w = 0; w < 4; w++)
        st[w][c] = st[w][c] ^ ks[1919-128*rd-8*(4*c+w) -: 8];
      if (dec && rd > 0 && rd < nr) begin
        tp = st;
        for (int w = 0; w < 4; w++) for (int c = 0; c < 4; c++) begin
          v = 8'h00;
          for (int j = 0; j < 4; j++) v = v ^ gm(8'(cd[(j-w+4)%4]), tp[j][c]);
          st[w][c] = v;
        end
      end
    end
    for (int c = 0; c < 4; c++) for (int w = 0; w < 4; w++) o[127-8*(4*c+w) -: 8] = st[w][c];
    return o;
  endfunction

  // ---------------- drivers ----------------
  // Called on the negedge right after the accepting posedge. Latency counts the
  // cycle in which the block was presented, so it comes out as nr+1.
  task automatic wait_out(input int d, output int lat, output int bc, output logic [127:0] res);
    int cnt = 0;
    bc = 0;
    while (!ov[d] && cnt < 60) begin
      if (bz[d]) bc++;
      @(negedge clk);
      cnt++;
    end
    lat = cnt + 1;
    res = rs[d];
  endtask

  task automatic run_block(input int d, input logic dec, input logic [127:0] m,
                           output int lat, output int bc, output logic [127:0] res);
    iv[d] = 1'b1;
    mode  = dec;
    msg   = m;
    @(negedge clk);
    iv[d] = 1'b0;
    wait_out(d, lat, bc, res);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    for (int d = 0; d < 3; d++) begin
      vecs++;
      if ({ir[d], ov[d], bz[d], rs[d]} !== 131'h0) begin
        errs++;
        $display("FAIL reset_state dut%0d: got rdy=%b ov=%b busy=%b res=%h, want all zero",
                 d, ir[d], ov[d], bz[d], rs[d]);
      end
    end
    rst_n = 1'b1;
    #1;
    for (int d = 0; d < 3; d++) begin
      vecs++;
      if (ir[d] !== 1'b1) begin
        errs++;
        $display("FAIL reset_release_ready dut%0d: got %b want 1", d, ir[d]);
      end
    end
  endtask

  task automatic test_known_vectors();
    logic [127:0] ct [3] = '{128'h69c4e0d86a7b0430d8cdb78070b4c55a,
                             128'hdda97ca4864cdfe06eaf70a0ec0d7191,
                             128'h8ea2b7ca516745bfeafc49904b496089};
    logic [127:0] res;
    int lat, bc;
    for (int d = 0; d < 3; d++) begin
      ksf[d] = expand(4 + 2*d, KEY);
      @(negedge clk);
      run_block(d, 1'b0, PT, lat, bc, res);
      vecs++;
      if (res !== ct[d] || lat !== 11 + 2*d || bc !== 10 + 2*d) begin
        errs++;
        $display("FAIL known_encrypt dut%0d: got %h lat=%0d busy=%0d, want %h lat=%0d busy=%0d",
                 d, res, lat, bc, ct[d], 11 + 2*d, 10 + 2*d);
      end
      @(negedge clk);
      run_block(d, 1'b1, ct[d], lat, bc, res);
      vecs++;
      if (res !== PT || lat !== 11 + 2*d) begin
        errs++;
        $display("FAIL known_decrypt dut%0d: got %h lat=%0d, want %h lat=%0d", d, res, lat, PT, 11 + 2*d);
      end
    end
  endtask

  task automatic test_random();
    logic [255:0] key;
    logic [127:0] m, exp, res;
    logic dec;
    int lat, bc;
    for (int d = 0; d < 3; d++) begin
      for (int n = 0; n < 6; n++) begin
        for (int j = 0; j < 8; j++) key[32*j +: 32] = $urandom;
        for (int j = 0; j < 4; j++) m[32*j +: 32] = $urandom;
        dec    = 1'($urandom_range(0, 1));
        ksf[d] = expand(4 + 2*d, key);
        exp    = model(10 + 2*d, ksf[d], dec, m);
        @(negedge clk);
        run_block(d, dec, m, lat, bc, res);
        vecs++;
        if (res !== exp || lat !== 11 + 2*d) begin
          errs++;
          $display("FAIL random dut%0d mode=%b: got %h lat=%0d, want %h lat=%0d", d, dec, res, lat, exp, 11 + 2*d);
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [127:0] m, ct, res;
    int lat, bc;
    for (int j = 0; j < 4; j++) m[32*j +: 32] = $urandom;
    ksf[0] = expand(4, KEY);
    ct = model(10, ksf[0], 1'b0, m);
    out_ready = 1'b0;
    @(negedge clk);
    run_block(0, 1'b0, m, lat, bc, res);
    vecs++;
    if (res !== ct) begin
      errs++;
      $display("FAIL backpressure_first: got %h want %h", res, ct);
    end
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      vecs++;
      if ({ov[0], ir[0], rs[0]} !== {1'b1, 1'b0, ct}) begin
        errs++;
        $display("FAIL backpressure_hold cyc%0d: ov=%b rdy=%b res=%h, want ov=1 rdy=0 res=%h",
                 k, ov[0], ir[0], rs[0], ct);
      end
    end
    out_ready = 1'b1;
    iv[0] = 1'b1;
    mode  = 1'b1;
    msg   = ct;
    #1;
    vecs++;
    if (ir[0] !== 1'b1) begin
      errs++;
      $display("FAIL handoff_ready: got %b want 1", ir[0]);
    end
    @(negedge clk);
    iv[0] = 1'b0;
    vecs++;
    if (ov[0] !== 1'b0 || bz[0] !== 1'b1) begin
      errs++;
      $display("FAIL handoff_no_bubble: ov=%b busy=%b, want ov=0 busy=1", ov[0], bz[0]);
    end
    wait_out(0, lat, bc, res);
    vecs++;
    if (res !== m || lat !== 11) begin
      errs++;
      $display("FAIL back_to_back_decrypt: got %h lat=%0d, want %h lat=11", res, lat, m);
    end
  endtask

  task automatic test_reset_mid();
    logic [127:0] res;
    int lat, bc, seen = 0;
    ksf[0] = expand(4, KEY);
    @(negedge clk);
    iv[0] = 1'b1;
    mode  = 1'b0;
    msg   = PT;
    @(negedge clk);
    iv[0] = 1'b0;
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    #1;
    vecs++;
    if ({ir[0], ov[0], bz[0], rs[0]} !== 131'h0) begin
      errs++;
      $display("FAIL reset_mid_state: rdy=%b ov=%b busy=%b res=%h, want all zero", ir[0], ov[0], bz[0], rs[0]);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 15; k++) begin
      @(negedge clk);
      if (ov[0]) seen++;
    end
    vecs++;
    if (seen !== 0) begin
      errs++;
      $display("FAIL reset_mid_no_output: out_valid seen %0d cycles, want 0", seen);
    end
    run_block(0, 1'b0, PT, lat, bc, res);
    vecs++;
    if (res !== 128'h69c4e0d86a7b0430d8cdb78070b4c55a || lat !== 11) begin
      errs++;
      $display("FAIL reset_mid_fresh: got %h lat=%0d, want 69c4e0d86a7b0430d8cdb78070b4c55a lat=11", res, lat);
    end
  endtask

  task automatic test_ignore_inputs();
    logic [127:0] m, exp;
    int cnt = 0;
    for (int j = 0; j < 4; j++) m[32*j +: 32] = $urandom;
    ksf[1] = expand(6, KEY);
    exp = model(12, ksf[1], 1'b1, m);
    @(negedge clk);
    iv[1] = 1'b1;
    mode  = 1'b1;
    msg   = m;
    @(negedge clk);
    while (!ov[1] && cnt < 60) begin
      msg  = {$urandom, $urandom, $urandom, $urandom};
      mode = 1'($urandom_range(0, 1));
      @(negedge clk);
      cnt++;
    end
    iv[1] = 1'b0;
    vecs++;
    if (rs[1] !== exp || cnt + 1 !== 13) begin
      errs++;
      $display("FAIL ignore_inputs: got %h lat=%0d, want %h lat=13", rs[1], cnt + 1, exp);
    end
    @(negedge clk);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int d = 0; d < 3; d++) begin
      iv[d]  = 1'b0;
      ksf[d] = '0;
    end
    mode      = 1'b0;
    msg       = '0;
    out_ready = 1'b1;
    rst_n     = 1'b0;
    build_tables();
    test_reset();
    test_known_vectors();
    test_random();
    test_back_to_back();
    test_reset_mid();
    test_ignore_inputs();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
